// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
// Operands load in parallel; the result and final carry are presented in parallel with a done pulse.

module full_adder_case (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    always_comb begin
        {co, s} = 2'b00;
        case ({a, b, ci})
            3'b000:                 {co, s} = 2'b00;
            3'b001, 3'b010, 3'b100: {co, s} = 2'b01;
            3'b011, 3'b101, 3'b110: {co, s} = 2'b10;
            3'b111:                 {co, s} = 2'b11;
            default:                {co, s} = 2'b00;
        endcase
    end
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sa_q, sb_q, part_q, sum_q;
    logic [WIDTH-1:0]   part_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               c_q, cout_q, busy_q, done_q;
    logic               fa_s, fa_co;

    full_adder_case u_fa (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign part_d = {fa_s, part_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q   <= sa_q >> 1;
                    sb_q   <= sb_q >> 1;
                    part_q <= part_d;
                    c_q    <= fa_co;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= part_d;
                        cout_q  <= fa_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 scenarios plus an exhaustive WIDTH=3 sweep.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one add, scramble the inputs, return edges from accept to done.
    task automatic do_add8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           output int edges);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        tick;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1;
        edges = 0;
        while (done8 !== 1'b1 && edges < 20) begin
            tick;
            edges++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done8); end
        total++; if (sum8 !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", sum8); end
        total++; if (cout8 !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout8); end
        total++; if (busy3 !== 1'b0 || done3 !== 1'b0 || sum3 !== 3'd0 || cout3 !== 1'b0) begin
            bad++; $display("FAIL reset_w3 got=%b%b%h%b want=0000", busy3, done3, sum3, cout3);
        end
    endtask

    task automatic test_basic;
        int edges;
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy8); end
        edges = 0;
        while (done8 !== 1'b1 && edges < 20) begin
            tick;
            edges++;
        end
        total++; if (edges != 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", edges); end
        total++; if (sum8 !== 8'h10) begin bad++; $display("FAIL basic_sum got=%h want=10", sum8); end
        total++; if (cout8 !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b want=0", cout8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL basic_busy_done got=%b want=0", busy8); end
        tick;
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", done8); end
    endtask

    task automatic test_carry;
        int edges;
        do_add8(8'hFF, 8'h01, 1'b0, edges);
        total++; if ({cout8, sum8} !== 9'h100 || edges != 8) begin
            bad++; $display("FAIL carry_ripple got=%b_%h e=%0d want=1_00 e=8", cout8, sum8, edges);
        end
        tick;
        do_add8(8'hAA, 8'h55, 1'b1, edges);
        total++; if ({cout8, sum8} !== 9'h100) begin
            bad++; $display("FAIL carry_alt got=%b_%h want=1_00", cout8, sum8);
        end
        tick;
        do_add8(8'h3C, 8'h5A, 1'b0, edges);
        total++; if ({cout8, sum8} !== 9'h096) begin
            bad++; $display("FAIL carry_mix got=%b_%h want=0_96", cout8, sum8);
        end
        tick;
        do_add8(8'h80, 8'h80, 1'b1, edges);
        total++; if ({cout8, sum8} !== 9'h101) begin
            bad++; $display("FAIL carry_msb got=%b_%h want=1_01", cout8, sum8);
        end
        tick;
    endtask

    task automatic test_ignore_start;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick;
        for (int i = 1; i <= 8; i++) begin
            total++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                bad++; $display("FAIL ign_run%0d busy=%b done=%b want busy=1 done=0", i, busy8, done8);
            end
            total++; if ({cout8, sum8} !== 9'h101) begin
                bad++; $display("FAIL ign_hold%0d got=%b_%h want=1_01", i, cout8, sum8);
            end
            start8 = (i == 3) || (i == 8);
            a8 = 8'hF0; b8 = 8'hF0; cin8 = 1'b1;
            tick;
        end
        total++; if (done8 !== 1'b1 || {cout8, sum8} !== 9'h046) begin
            bad++; $display("FAIL ign_done got=%b %b_%h want=1 0_46", done8, cout8, sum8);
        end
        tick;
        start8 = 1'b0;
        total++; if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h46) begin
            bad++; $display("FAIL ign_after got done=%b busy=%b sum=%h want 0 0 46", done8, busy8, sum8);
        end
        tick;
        total++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            bad++; $display("FAIL ign_idle got done=%b busy=%b want 0 0", done8, busy8);
        end
    endtask

    task automatic test_reset_mid;
        int edges;
        do_add8(8'hFF, 8'hFF, 1'b1, edges);
        total++; if ({cout8, sum8} !== 9'h1FF) begin
            bad++; $display("FAIL rmid_pre got=%b_%h want=1_ff", cout8, sum8);
        end
        tick;
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick; tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++; if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            bad++; $display("FAIL rmid_clear got=%b%b_%b_%h want=00_0_00", busy8, done8, cout8, sum8);
        end
        tick;
        total++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++; $display("FAIL rmid_idle got busy=%b done=%b want 0 0", busy8, done8);
        end
        do_add8(8'h21, 8'h43, 1'b1, edges);
        total++; if ({cout8, sum8} !== 9'h065 || edges != 8) begin
            bad++; $display("FAIL rmid_next got=%b_%h e=%0d want=0_65 e=8", cout8, sum8, edges);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [7:0] opa [4];
        logic [7:0] opb [4];
        logic       opc [4];
        logic [8:0] exp [4];
        int         edges;
        opa = '{8'h01, 8'hF0, 8'h7F, 8'h10};
        opb = '{8'h02, 8'h20, 8'h7F, 8'h10};
        opc = '{1'b0, 1'b1, 1'b1, 1'b0};
        exp = '{9'h003, 9'h111, 9'h0FF, 9'h020};
        a8 = opa[0]; b8 = opb[0]; cin8 = opc[0]; start8 = 1'b1;
        tick;
        a8 = opa[1]; b8 = opb[1]; cin8 = opc[1];
        edges = 0;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) start8 = 1'b0;
            while (done8 !== 1'b1 && edges < 30) begin
                tick;
                edges++;
            end
            total++; if (edges != ((j == 0) ? 8 : 10)) begin
                bad++; $display("FAIL b2b_period%0d got=%0d want=%0d", j, edges, (j == 0) ? 8 : 10);
            end
            total++; if ({cout8, sum8} !== exp[j]) begin
                bad++; $display("FAIL b2b_sum%0d got=%b_%h want=%h", j, cout8, sum8, exp[j]);
            end
            tick;
            tick;
            edges = 2;
            if (j < 2) begin
                a8 = opa[j+2]; b8 = opb[j+2]; cin8 = opc[j+2];
            end
        end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL b2b_stop got busy=%b want 0", busy8); end
    endtask

    task automatic test_width3;
        int edges;
        int nbad;
        logic [3:0] want;
        nbad = 0;
        for (int k = 0; k < 128; k++) begin
            a3 = 3'(k >> 4); b3 = 3'(k >> 1); cin3 = k[0]; start3 = 1'b1;
            want = 4'(a3) + 4'(b3) + 4'(cin3);
            tick;
            start3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
            edges = 0;
            while (done3 !== 1'b1 && edges < 10) begin
                tick;
                edges++;
            end
            total++; if ({cout3, sum3} !== want || edges != 3) begin
                bad++; nbad++;
                if (nbad <= 8) $display("FAIL w3_k%0d got=%b_%0d e=%0d want=%0d e=3", k, cout3, sum3, edges, want);
            end
            tick;
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_width3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
